// File: rtl/ex_muldiv_stage.sv
// EX stage: single-cycle ALU pass-through plus an iterative RV32M multiply/divide unit.
// The EX/MEM register takes a bubble on every stall cycle and the M result on the DONE cycle.
module ex_muldiv_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            valid_ID,
    input  logic            ctrl_md_ID,
    input  logic [2:0]      md_op_ID,
    input  logic [XLEN-1:0] rs1_ID,
    input  logic [XLEN-1:0] rs2_ID,
    input  logic [XLEN-1:0] alu_out_ID,
    input  logic [4:0]      reg_wb_addr_ID,
    input  logic            ctrl_reg_write_ID,
    output logic            stall_EX,
    output logic            md_busy,
    output logic            valid_EX,
    output logic [XLEN-1:0] result_EX,
    output logic [4:0]      reg_wb_addr_EX,
    output logic            ctrl_reg_write_EX
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_dbz;
    logic [4:0]          r_addr;
    logic                r_wr;

    logic                w_start;
    logic                w_is_div;
    logic                w_s1;
    logic                w_s2;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [XLEN:0]       w_m_sum;
    logic [2*XLEN-1:0]   w_m_next;
    logic [XLEN:0]       w_d_shift;
    logic [XLEN:0]       w_d_diff;
    logic                w_d_ge;
    logic [2*XLEN-1:0]   w_d_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_result;

    assign w_start  = (r_state == S_IDLE) && valid_ID && ctrl_md_ID && !flush;
    assign w_is_div = md_op_ID[2];
    assign w_s1     = rs1_ID[XLEN-1] && (md_op_ID inside {3'd1, 3'd2, 3'd4, 3'd6});
    assign w_s2     = rs2_ID[XLEN-1] && (md_op_ID inside {3'd1, 3'd4, 3'd6});
    assign w_a_mag  = w_s1 ? -rs1_ID : rs1_ID;
    assign w_b_mag  = w_s2 ? -rs2_ID : rs2_ID;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign w_m_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_m_next = {w_m_sum, r_acc[XLEN-1:1]};

    // Divide: {remainder, quotient} shift left; restore by simply not taking the difference.
    assign w_d_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_d_diff  = w_d_shift - {1'b0, r_b};
    assign w_d_ge    = !w_d_diff[XLEN];
    assign w_d_next  = {(w_d_ge ? w_d_diff[XLEN-1:0] : w_d_shift[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_d_ge};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_dbz ? '1 : (r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
    assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_result = w_rem;
        case (r_op)
            3'd0:                w_result = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_result = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_result = w_quot;
            default:             w_result = w_rem;
        endcase
    end

    assign stall_EX = !rst && !flush &&
                      (((r_state == S_IDLE) && valid_ID && ctrl_md_ID) || (r_state == S_BUSY));
    assign md_busy  = (r_state == S_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state <= S_BUSY;
                    r_cnt   <= '0;
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN-1))
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath state carries no reset: it is always reloaded before it is observed.
    always_ff @(posedge clk) begin
        if (w_start && !rst) begin
            r_op    <= md_op_ID;
            r_b     <= w_is_div ? w_b_mag : w_a_mag;
            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            r_dbz   <= (rs2_ID == '0);
            r_addr  <= reg_wb_addr_ID;
            r_wr    <= ctrl_reg_write_ID;
        end else if (r_state == S_BUSY) begin
            r_acc <= r_op[2] ? w_d_next : w_m_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_EX          <= 1'b0;
            result_EX         <= '0;
            reg_wb_addr_EX    <= '0;
            ctrl_reg_write_EX <= 1'b0;
        end else if (flush || stall_EX) begin
            valid_EX          <= 1'b0;
            ctrl_reg_write_EX <= 1'b0;
        end else if (r_state == S_DONE) begin
            valid_EX          <= 1'b1;
            result_EX         <= w_result;
            reg_wb_addr_EX    <= r_addr;
            ctrl_reg_write_EX <= r_wr;
        end else begin
            valid_EX          <= valid_ID;
            result_EX         <= alu_out_ID;
            reg_wb_addr_EX    <= reg_wb_addr_ID;
            ctrl_reg_write_EX <= ctrl_reg_write_ID && valid_ID;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed bench for ex_muldiv_stage: M-op results, stall length, bubbles, rst/flush aborts,
// ALU pass-through and a second instance at XLEN=16.
module tb_ex_muldiv_stage;

    logic        clk = 1'b0;
    logic        rst, flush, valid_ID, ctrl_md_ID, ctrl_reg_write_ID;
    logic [2:0]  md_op_ID;
    logic [31:0] rs1_ID, rs2_ID, alu_out_ID;
    logic [4:0]  reg_wb_addr_ID;
    logic        stall_EX, md_busy, valid_EX, ctrl_reg_write_EX;
    logic [31:0] result_EX;
    logic [4:0]  reg_wb_addr_EX;

    logic        valid16, md16, wr16_i;
    logic [2:0]  op16;
    logic [15:0] a16, b16, alu16;
    logic        stall16, busy16, vld16, wr16;
    logic [15:0] res16;
    logic [4:0]  addr16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_muldiv_stage #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_ID(valid_ID), .ctrl_md_ID(ctrl_md_ID),
        .md_op_ID(md_op_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .alu_out_ID(alu_out_ID),
        .reg_wb_addr_ID(reg_wb_addr_ID), .ctrl_reg_write_ID(ctrl_reg_write_ID),
        .stall_EX(stall_EX), .md_busy(md_busy), .valid_EX(valid_EX), .result_EX(result_EX),
        .reg_wb_addr_EX(reg_wb_addr_EX), .ctrl_reg_write_EX(ctrl_reg_write_EX)
    );

    ex_muldiv_stage #(.XLEN(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst(rst), .flush(1'b0), .valid_ID(valid16), .ctrl_md_ID(md16),
        .md_op_ID(op16), .rs1_ID(a16), .rs2_ID(b16), .alu_out_ID(alu16),
        .reg_wb_addr_ID(5'd4), .ctrl_reg_write_ID(wr16_i),
        .stall_EX(stall16), .md_busy(busy16), .valid_EX(vld16), .result_EX(res16),
        .reg_wb_addr_EX(addr16), .ctrl_reg_write_EX(wr16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the result sits in EX/MEM.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int  stalls = 0;
        int  early  = 0;
        bit  done   = 0;
        logic st;
        valid_ID = 1'b1; ctrl_md_ID = 1'b1; md_op_ID = op; rs1_ID = a; rs2_ID = b;
        reg_wb_addr_ID = 5'd7; ctrl_reg_write_ID = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1 st = stall_EX;
            if (st) stalls++;
            @(negedge clk);
            if (!st) begin
                done = 1;
                break;
            end
            if (valid_EX) early++;
        end
        chk({tag, "_done"},   64'(done), 64'd1);
        chk({tag, "_res"},    64'(result_EX), 64'(exp));
        chk({tag, "_vld"},    64'(valid_EX), 64'd1);
        chk({tag, "_wr"},     64'(ctrl_reg_write_EX), 64'd1);
        chk({tag, "_stalls"}, 64'(stalls), 64'd33);
        chk({tag, "_bubble"}, 64'(early), 64'd0);
    endtask

    task automatic quiet_window(input string tag);
        int pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid_EX || ctrl_reg_write_EX) pulses++;
        end
        chk(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid_ID = 1'b0; ctrl_md_ID = 1'b0; ctrl_reg_write_ID = 1'b0;
        md_op_ID = 3'd0; rs1_ID = '0; rs2_ID = '0; alu_out_ID = '0; reg_wb_addr_ID = '0;
        valid16 = 1'b0; md16 = 1'b0; wr16_i = 1'b0; op16 = 3'd0; a16 = '0; b16 = '0; alu16 = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld",   64'(valid_EX), 64'd0);
        chk("rst_res",   64'(result_EX), 64'd0);
        chk("rst_addr",  64'(reg_wb_addr_EX), 64'd0);
        chk("rst_wr",    64'(ctrl_reg_write_EX), 64'd0);
        chk("rst_busy",  64'(md_busy), 64'd0);
        chk("rst_vld16", 64'(vld16), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_md("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run_md("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_md("mulh",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_md("mulhsu",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
        run_md("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_md("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_md("div_n7",  3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_md("rem_n7",  3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_md("divu_99", 3'd5, 32'd100,      32'd7,        32'd14);
        run_md("div_dz",  3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
        run_md("rem_dz",  3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
        run_md("divu_dz", 3'd5, 32'd123,      32'd0,        32'hFFFFFFFF);
        run_md("remu_dz", 3'd7, 32'd123,      32'd0,        32'd123);

        // ALU op right behind the M op.
        ctrl_md_ID = 1'b0; alu_out_ID = 32'd5; reg_wb_addr_ID = 5'd9;
        #1 chk("add_nostall", 64'(stall_EX), 64'd0);
        @(negedge clk);
        chk("add_res",  64'(result_EX), 64'd5);
        chk("add_vld",  64'(valid_EX), 64'd1);
        chk("add_addr", 64'(reg_wb_addr_EX), 64'd9);
        valid_ID = 1'b0;
        @(negedge clk);
        chk("idle_vld", 64'(valid_EX), 64'd0);
        chk("idle_wr",  64'(ctrl_reg_write_EX), 64'd0);

        // Reset in the middle of a multiply.
        valid_ID = 1'b1; ctrl_md_ID = 1'b1; md_op_ID = 3'd0; rs1_ID = 32'd3; rs2_ID = 32'd4;
        repeat (11) @(negedge clk);
        chk("pre_rst_busy", 64'(md_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid_ID = 1'b0; ctrl_md_ID = 1'b0;
        #1;
        chk("mrst_busy",  64'(md_busy), 64'd0);
        chk("mrst_stall", 64'(stall_EX), 64'd0);
        chk("mrst_vld",   64'(valid_EX), 64'd0);
        chk("mrst_res",   64'(result_EX), 64'd0);
        chk("mrst_wr",    64'(ctrl_reg_write_EX), 64'd0);
        quiet_window("mrst_nowb");

        // Flush in the middle of a divide; the same-cycle ID op is dropped.
        valid_ID = 1'b1; ctrl_md_ID = 1'b1; md_op_ID = 3'd5; rs1_ID = 32'd100; rs2_ID = 32'd7;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        #1 chk("fl_stall", 64'(stall_EX), 64'd0);
        @(negedge clk);
        flush = 1'b0; valid_ID = 1'b0; ctrl_md_ID = 1'b0;
        #1;
        chk("fl_busy", 64'(md_busy), 64'd0);
        chk("fl_vld",  64'(valid_EX), 64'd0);
        quiet_window("fl_nowb");
        valid_ID = 1'b1; alu_out_ID = 32'd9; ctrl_reg_write_ID = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; valid_ID = 1'b0;
        chk("fl_alu_vld", 64'(valid_EX), 64'd0);
        chk("fl_alu_wr",  64'(ctrl_reg_write_EX), 64'd0);

        // Same multiply on the 16-bit instance.
        begin
            int   stalls = 0;
            bit   done   = 0;
            logic st;
            valid16 = 1'b1; md16 = 1'b1; op16 = 3'd0; a16 = 16'd7; b16 = 16'hFFFD; wr16_i = 1'b1;
            for (int c = 0; c < 60; c++) begin
                #1 st = stall16;
                if (st) stalls++;
                @(negedge clk);
                if (!st) begin
                    done = 1;
                    break;
                end
            end
            chk("m16_done",   64'(done), 64'd1);
            chk("m16_res",    64'(res16), 64'hFFEB);
            chk("m16_vld",    64'(vld16), 64'd1);
            chk("m16_addr",   64'(addr16), 64'd4);
            chk("m16_stalls", 64'(stalls), 64'd17);
            valid16 = 1'b0;
            @(negedge clk);
            chk("m16_after",  64'(vld16 | wr16 | busy16), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
